// File: rtl/ai_job_sequencer.sv
// Sequences one AI move computation per job: reset the AI core, pulse start,
// wait for done under a watchdog and abort control, then hand back the result.
module ai_job_sequencer #(
  parameter int DATA_W     = 64,
  parameter int RST_CYCLES = 4,
  parameter int TMO_W      = 32
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iJOB_Valid,
  output logic              oJOB_Ready,
  input  logic [DATA_W-1:0] iJOB_DATA,
  input  logic [7:0]        iJOB_COLOR,
  input  logic [16:0]       iJOB_MOVECNT,
  input  logic [TMO_W-1:0]  iTIMEOUT,
  input  logic              iABORT,
  output logic              oRES_Valid,
  input  logic              iRES_Ready,
  output logic [DATA_W-1:0] oRES_DATA,
  output logic [1:0]        oRES_STATUS,
  output logic              oAI_RSTn,
  output logic              oAI_Start,
  output logic [DATA_W-1:0] oAI_DATA,
  output logic [7:0]        oAI_COLOR,
  output logic [16:0]       oAI_MOVECNT,
  input  logic              iAI_Done,
  input  logic [DATA_W-1:0] iAI_RESULT,
  output logic              oBUSY,
  output logic [15:0]       oJOB_CNT,
  output logic [7:0]        oTMO_CNT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TMO = 2'b01;
  localparam logic [1:0] ST_ABT = 2'b10;

  localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES);
  localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO = '0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]        state;
  logic [RC_W-1:0]   rst_cnt;
  logic [TMO_W-1:0]  wdog;
  logic [TMO_W-1:0]  tmo_lim;
  logic              job_ready;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        res_status;
  logic              ai_rstn;
  logic              ai_start;
  logic [DATA_W-1:0] ai_data;
  logic [7:0]        ai_color;
  logic [16:0]       ai_movecnt;
  logic              busy;
  logic [15:0]       job_cnt;
  logic [7:0]        tmo_cnt;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state      <= S_IDLE;
      rst_cnt    <= '0;
      wdog       <= '0;
      tmo_lim    <= '0;
      job_ready  <= 1'b1;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_status <= ST_OK;
      ai_rstn    <= 1'b0;
      ai_start   <= 1'b0;
      ai_data    <= '0;
      ai_color   <= '0;
      ai_movecnt <= '0;
      busy       <= 1'b0;
      job_cnt    <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iJOB_Valid) begin
            ai_data    <= iJOB_DATA;
            ai_color   <= iJOB_COLOR;
            ai_movecnt <= iJOB_MOVECNT;
            tmo_lim    <= iTIMEOUT;
            job_ready  <= 1'b0;
            busy       <= 1'b1;
            ai_rstn    <= 1'b0;
            rst_cnt    <= RC_ONE;
            state      <= S_RST;
          end
        end
        S_RST: begin
          if (iABORT) begin
            res_valid  <= 1'b1;
            res_status <= ST_ABT;
            res_data   <= '0;
            state      <= S_RESP;
          end else if (rst_cnt == RC_LAST) begin
            ai_rstn  <= 1'b1;
            ai_start <= 1'b1;
            state    <= S_START;
          end else begin
            rst_cnt <= rst_cnt + RC_ONE;
          end
        end
        S_START: begin
          ai_start <= 1'b0;
          if (iABORT) begin
            ai_rstn    <= 1'b0;
            res_valid  <= 1'b1;
            res_status <= ST_ABT;
            res_data   <= '0;
            state      <= S_RESP;
          end else begin
            wdog  <= TMO_ONE;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Same-cycle priority: done wins over timeout, timeout over abort.
          if (iAI_Done) begin
            res_valid  <= 1'b1;
            res_status <= ST_OK;
            res_data   <= iAI_RESULT;
            state      <= S_RESP;
          end else if ((tmo_lim != TMO_ZERO) && (wdog == tmo_lim)) begin
            ai_rstn    <= 1'b0;
            res_valid  <= 1'b1;
            res_status <= ST_TMO;
            res_data   <= '0;
            tmo_cnt    <= sat_inc8(tmo_cnt);
            state      <= S_RESP;
          end else if (iABORT) begin
            ai_rstn    <= 1'b0;
            res_valid  <= 1'b1;
            res_status <= ST_ABT;
            res_data   <= '0;
            state      <= S_RESP;
          end else begin
            wdog <= wdog + TMO_ONE;
          end
        end
        S_RESP: begin
          if (iRES_Ready) begin
            res_valid <= 1'b0;
            job_cnt   <= job_cnt + 16'd1;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign oJOB_Ready  = job_ready;
  assign oRES_Valid  = res_valid;
  assign oRES_DATA   = res_data;
  assign oRES_STATUS = res_status;
  assign oAI_RSTn    = ai_rstn;
  assign oAI_Start   = ai_start;
  assign oAI_DATA    = ai_data;
  assign oAI_COLOR   = ai_color;
  assign oAI_MOVECNT = ai_movecnt;
  assign oBUSY       = busy;
  assign oJOB_CNT    = job_cnt;
  assign oTMO_CNT    = tmo_cnt;

endmodule

// File: tb/tb_ai_job_sequencer.sv
// Bench for ai_job_sequencer: directed and randomized jobs against a
// per-job outcome model (which event ends the job, when, with what status).
module tb_ai_job_sequencer;
  localparam int DW = 64;
  localparam int R  = 4;
  localparam int TW = 32;

  logic          iCLK;
  logic          iRST_n;
  logic          iJOB_Valid;
  logic          oJOB_Ready;
  logic [DW-1:0] iJOB_DATA;
  logic [7:0]    iJOB_COLOR;
  logic [16:0]   iJOB_MOVECNT;
  logic [TW-1:0] iTIMEOUT;
  logic          iABORT;
  logic          oRES_Valid;
  logic          iRES_Ready;
  logic [DW-1:0] oRES_DATA;
  logic [1:0]    oRES_STATUS;
  logic          oAI_RSTn;
  logic          oAI_Start;
  logic [DW-1:0] oAI_DATA;
  logic [7:0]    oAI_COLOR;
  logic [16:0]   oAI_MOVECNT;
  logic          iAI_Done;
  logic [DW-1:0] iAI_RESULT;
  logic          oBUSY;
  logic [15:0]   oJOB_CNT;
  logic [7:0]    oTMO_CNT;

  int checks = 0;
  int failures = 0;
  logic [15:0] m_job_cnt = '0;
  logic [7:0]  m_tmo_cnt = '0;

  ai_job_sequencer #(.DATA_W(DW), .RST_CYCLES(R), .TMO_W(TW)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iJOB_Valid(iJOB_Valid), .oJOB_Ready(oJOB_Ready),
    .iJOB_DATA(iJOB_DATA), .iJOB_COLOR(iJOB_COLOR), .iJOB_MOVECNT(iJOB_MOVECNT),
    .iTIMEOUT(iTIMEOUT), .iABORT(iABORT),
    .oRES_Valid(oRES_Valid), .iRES_Ready(iRES_Ready),
    .oRES_DATA(oRES_DATA), .oRES_STATUS(oRES_STATUS),
    .oAI_RSTn(oAI_RSTn), .oAI_Start(oAI_Start),
    .oAI_DATA(oAI_DATA), .oAI_COLOR(oAI_COLOR), .oAI_MOVECNT(oAI_MOVECNT),
    .iAI_Done(iAI_Done), .iAI_RESULT(iAI_RESULT),
    .oBUSY(oBUSY), .oJOB_CNT(oJOB_CNT), .oTMO_CNT(oTMO_CNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    iJOB_Valid = 1'b0;
    iABORT     = 1'b0;
    iRES_Ready = 1'b0;
    iAI_Done   = 1'b0;
    iAI_RESULT = '0;
  endtask

  task automatic chk_reset_values();
    chk("rst_job_ready", 64'(oJOB_Ready), 64'd1);
    chk("rst_res_valid", 64'(oRES_Valid), 64'd0);
    chk("rst_res_status", 64'(oRES_STATUS), 64'd0);
    chk("rst_res_data", oRES_DATA, 64'd0);
    chk("rst_ai_rstn", 64'(oAI_RSTn), 64'd0);
    chk("rst_ai_start", 64'(oAI_Start), 64'd0);
    chk("rst_ai_data", oAI_DATA, 64'd0);
    chk("rst_ai_color", 64'(oAI_COLOR), 64'd0);
    chk("rst_ai_movecnt", 64'(oAI_MOVECNT), 64'd0);
    chk("rst_busy", 64'(oBUSY), 64'd0);
    chk("rst_job_cnt", 64'(oJOB_CNT), 64'd0);
    chk("rst_tmo_cnt", 64'(oTMO_CNT), 64'd0);
  endtask

  // kd: WAIT cycle at which done rises (0 = never); ab: cycle after accept
  // carrying a one-cycle abort pulse (0 = none); rst_at: cycle to hit reset.
  task automatic run_job(input logic [63:0] d, input logic [7:0] col, input logic [16:0] mc,
                         input int tmo, input int kd, input int ab, input int rdy_dly,
                         input int rst_at, input logic [63:0] res);
    int resp_n;
    int kstar;
    logic [1:0] st;
    st = 2'b00;
    kstar = 1 << 30;
    if (ab >= 1 && ab <= R + 1) begin
      st = 2'b10;
      resp_n = ab + 1;
    end else begin
      if (ab > R + 1) begin kstar = ab - (R + 1); st = 2'b10; end
      if (tmo != 0 && tmo <= kstar) begin kstar = tmo; st = 2'b01; end
      if (kd > 0 && kd <= kstar) begin kstar = kd; st = 2'b00; end
      resp_n = (kstar == (1 << 30)) ? kstar : R + 2 + kstar;
    end

    @(negedge iCLK);
    chk("idle_job_ready", 64'(oJOB_Ready), 64'd1);
    chk("idle_busy", 64'(oBUSY), 64'd0);
    iJOB_Valid   = 1'b1;
    iJOB_DATA    = d;
    iJOB_COLOR   = col;
    iJOB_MOVECNT = mc;
    iTIMEOUT     = TW'(tmo);
    @(posedge iCLK);
    for (int n = 1; n < 4000; n++) begin
      @(negedge iCLK);
      iJOB_Valid   = 1'b0;
      iJOB_DATA    = {$urandom, $urandom};
      iJOB_COLOR   = 8'($urandom);
      iJOB_MOVECNT = 17'($urandom);
      iTIMEOUT     = TW'($urandom_range(1, 3));
      if (n == rst_at) begin
        iRST_n = 1'b0;
        #1;
        m_job_cnt = '0;
        m_tmo_cnt = '0;
        chk_reset_values();
        #1;
        iRST_n = 1'b1;
        clear_inputs();
        return;
      end
      if (n < resp_n) begin
        chk("ai_rstn", 64'(oAI_RSTn), 64'(n > R));
        chk("ai_start", 64'(oAI_Start), 64'(n == R + 1));
        chk("res_valid_busy", 64'(oRES_Valid), 64'd0);
      end else begin
        if (n == resp_n && st == 2'b01 && m_tmo_cnt != 8'hFF) m_tmo_cnt++;
        chk("res_valid", 64'(oRES_Valid), 64'd1);
        chk("res_status", 64'(oRES_STATUS), 64'(st));
        chk("res_data", oRES_DATA, (st == 2'b00) ? res : 64'd0);
        chk("resp_ai_rstn", 64'(oAI_RSTn), 64'(st == 2'b00));
        chk("resp_ai_start", 64'(oAI_Start), 64'd0);
      end
      chk("busy_job_ready", 64'(oJOB_Ready), 64'd0);
      chk("busy", 64'(oBUSY), 64'd1);
      chk("ai_data", oAI_DATA, d);
      chk("ai_color", 64'(oAI_COLOR), 64'(col));
      chk("ai_movecnt", 64'(oAI_MOVECNT), 64'(mc));
      chk("job_cnt", 64'(oJOB_CNT), 64'(m_job_cnt));
      chk("tmo_cnt", 64'(oTMO_CNT), 64'(m_tmo_cnt));

      iAI_Done   = (kd > 0 && n >= R + 1 + kd) || (n == 2);
      iAI_RESULT = (n == 2) ? {$urandom, $urandom} : res;
      iABORT     = (n == ab) || (n == resp_n + 1);
      iRES_Ready = (n >= resp_n + rdy_dly);
      if (iRES_Ready) begin
        iJOB_Valid = 1'b1;
        @(posedge iCLK);
        m_job_cnt++;
        @(negedge iCLK);
        chk("hs_job_ready", 64'(oJOB_Ready), 64'd1);
        chk("hs_busy", 64'(oBUSY), 64'd0);
        chk("hs_res_valid", 64'(oRES_Valid), 64'd0);
        chk("hs_job_cnt", 64'(oJOB_CNT), 64'(m_job_cnt));
        clear_inputs();
        return;
      end
      @(posedge iCLK);
    end
    chk("job_cycle_budget", 64'd1, 64'd0);
    clear_inputs();
  endtask

  initial begin
    int kd, tmo, ab;
    iRST_n       = 1'b0;
    iJOB_DATA    = '0;
    iJOB_COLOR   = '0;
    iJOB_MOVECNT = '0;
    iTIMEOUT     = '0;
    clear_inputs();
    repeat (2) @(negedge iCLK);
    chk_reset_values();
    iRST_n = 1'b1;

    // Directed scenarios.
    run_job(64'h0123_4567_89AB_CDEF, 8'h01, 17'd12, 0, 10, 0, 0, 0, 64'hDEAD_BEEF_0000_1111);
    run_job(64'h1111_2222_3333_4444, 8'h02, 17'd3, 20, 0, 0, 1, 0, 64'h55);
    chk("tmo_cnt_after_first_timeout", 64'(oTMO_CNT), 64'd1);
    run_job(64'hAAAA_0000_BBBB_0000, 8'h03, 17'd7, 8, 8, 0, 0, 0, 64'hC0FFEE);
    run_job(64'h5555_6666_7777_8888, 8'h04, 17'd9, 0, 3, 2, 0, 0, 64'h77);
    run_job(64'h9999_AAAA_BBBB_CCCC, 8'h05, 17'd1, 0, 2, 0, 50, 0, 64'h1234_5678);
    run_job(64'h0F0F_0F0F_0F0F_0F0F, 8'h06, 17'd2, 0, 0, R + 1, 0, 0, 64'h9);
    run_job(64'h0000_0000_0000_0042, 8'h07, 17'd4, 30, 0, R + 6, 2, 0, 64'h10);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      kd  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 25));
      tmo = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 25));
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      if (kd == 0 && tmo == 0 && ab == 0) kd = 4;
      run_job({$urandom, $urandom}, 8'($urandom), 17'($urandom), tmo, kd, ab,
              int'($urandom_range(0, 4)), 0, {$urandom, $urandom});
    end

    // Reset in the middle of WAIT, then a normal job.
    run_job(64'hFEED_FACE_CAFE_BABE, 8'h08, 17'd5, 0, 0, 0, 0, R + 5, 64'h0);
    run_job(64'h0123_4567_89AB_CDEF, 8'h09, 17'd6, 0, 5, 0, 0, 0, 64'h8888_7777);
    chk("job_cnt_after_reset", 64'(oJOB_CNT), 64'd1);

    // Timeout counter saturation.
    for (int j = 0; j < 257; j++)
      run_job(64'(j), 8'h0A, 17'(j), 1, 0, 0, 0, 0, 64'h0);
    chk("tmo_cnt_saturated", 64'(oTMO_CNT), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
